param_lifo_stack: RTL and testbench
===================================

Name: param_lifo_stack

Overview:
Parametrised LIFO stack for the LEG CPU data path. It generalises the fixed 8-bit, 32-entry push/pop stack to configurable word width and depth. It adds occupancy and full/empty flags, sticky overflow/underflow error flags, a synchronous flush, simultaneous push+pop (replace-top), and a registered pop-data port with a valid strobe. It serves as the call/return and operand stack behind the register file.

Parameters:
DATA_WIDTH, 8, width of each stack word in bits (>=1)
DEPTH, 32, number of entries (>=2; need not be a power of two)
CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count (derived, do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low (rst=0 at a rising edge resets the block)
clear  input  1  synchronous flush: empties the stack and clears the error flags
push  input  1  push request; value is written this cycle if accepted
pop  input  1  pop request
value  input  DATA_WIDTH  data to push
top  output  DATA_WIDTH  combinational peek of the current top entry; 0 when empty
data_out  output  DATA_WIDTH  registered popped word
out_valid  output  1  one-cycle strobe, high the cycle after an accepted pop
count  output  CNT_WIDTH  current occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  sticky: a push was rejected because the stack was full
underflow  output  1  sticky: a pop was rejected because the stack was empty

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array, write pointer = count. Array contents are not reset.
- Reset (rst=0): count=0, data_out=0, out_valid=0, overflow=0, underflow=0. Resulting flags: empty=1, full=0, top=0. Reset overrides all other inputs, including mid-operation.
- Priority per edge: rst > clear > push/pop.
- clear=1 (rst=1): count=0, overflow=0, underflow=0, out_valid=0. data_out holds its value. push/pop are ignored that cycle.
- top = mem[count-1] when count>0, else 0. It is purely combinational and reflects writes on the following cycle.
- push only:
  - not full: mem[count]<=value, count+=1.
  - full: no write, count unchanged, overflow<=1.
- pop only:
  - not empty: data_out<=mem[count-1], out_valid<=1, count-=1.
  - empty: count unchanged, out_valid<=0, data_out holds, underflow<=1.
- push+pop:
  - not empty (including full): replace-top. data_out<=old mem[count-1], out_valid<=1, mem[count-1]<=value, count unchanged. No error is flagged, even when full.
  - empty: treated as push only (mem[0]<=value, count=1, out_valid<=0). underflow<=1.
- out_valid is 0 on every cycle without an accepted pop. Pop latency is 1 cycle: the request at edge N gives data_out/out_valid valid after edge N.
- overflow and underflow stay set until rst or clear. Further rejected operations do not alter them otherwise.
- Count arithmetic never wraps: count stays in 0..DEPTH under all input combinations.
- Fully synchronous design: no combinational path from push/pop to any output. top depends only on state.

Test Plan:
- Reset with DATA_WIDTH=8, DEPTH=4: drive rst=0 for 2 cycles, then rst=1 -> count=0, empty=1, full=0, top=0x00, out_valid=0, overflow=0, underflow=0.
- LIFO order: push 0x11, 0x22, 0x33, then pop three times -> data_out 0x33, 0x22, 0x11 on successive cycles with out_valid=1 each cycle; after the third pop empty=1 and top=0x00.
- Full/overflow (DEPTH=4): push 0xA0..0xA3, then push 0xFF -> full=1, count=4, overflow=1, top=0xA3. Then pop -> data_out=0xA3; 0xFF never appears.
- Underflow and simultaneous ops:
  - pop on empty -> underflow=1, out_valid=0, count=0.
  - push+pop on empty with value 0x5A -> count=1, top=0x5A, out_valid=0.
  - push 0x6B then push+pop with 0x7C -> data_out=0x6B, out_valid=1, count=2, top=0x7C.
- Clear/reset mid-operation: with stack at count=3 and overflow=1, assert clear together with push -> count=0, overflow=0, no write. Repeat with rst=0 asserted alongside pop -> full reset state, out_valid=0.
- Non-power-of-two DEPTH=5, DATA_WIDTH=16: push 6 words 0x1000..0x1005 -> count=5, overflow=1. Then pop 6 times -> data_out 0x1004..0x1000, then underflow=1 with count stuck at 0.

Source files
------------

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with occupancy flags, sticky error flags, flush,
// replace-top on simultaneous push+pop, and a registered pop-data port.
module param_lifo_stack #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] value,
  output logic [DATA_WIDTH-1:0] top,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] top_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en;

  assign empty    = (count == '0);
  assign full     = (count == CNT_WIDTH'(DEPTH));
  assign top_addr = ADDR_WIDTH'(count - CNT_WIDTH'(1));
  assign top      = empty ? '0 : mem[top_addr];

  // Replace-top targets the current top slot; a plain push (or push+pop on
  // an empty stack) targets the slot at the write pointer.
  always_comb begin
    wr_addr = ADDR_WIDTH'(count);
    wr_en   = 1'b0;
    if (rst && !clear && push) begin
      if (pop && !empty) begin
        wr_addr = top_addr;
        wr_en   = 1'b1;
      end else if (!full) begin
        wr_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= value;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (push && pop) begin
        if (!empty) begin
          data_out  <= mem[top_addr];
          out_valid <= 1'b1;
        end else begin
          count     <= CNT_WIDTH'(1);
          underflow <= 1'b1;
        end
      end else if (push) begin
        if (!full) count    <= count + CNT_WIDTH'(1);
        else       overflow <= 1'b1;
      end else if (pop) begin
        if (!empty) begin
          data_out  <= mem[top_addr];
          out_valid <= 1'b1;
          count     <= count - CNT_WIDTH'(1);
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed bench for param_lifo_stack: an 8-bit/4-deep instance and a
// 16-bit/5-deep instance, checked against hand-computed values.
module tb_param_lifo_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, clear_a, push_a, pop_a;
  logic [7:0] value_a, top_a, data_out_a;
  logic [2:0] count_a;
  logic       out_valid_a, empty_a, full_a, overflow_a, underflow_a;

  logic        rst_b, clear_b, push_b, pop_b;
  logic [15:0] value_b, top_b, data_out_b;
  logic [2:0]  count_b;
  logic        out_valid_b, empty_b, full_b, overflow_b, underflow_b;

  int test_count = 0;
  int fail_count = 0;

  param_lifo_stack #(.DATA_WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .clear(clear_a), .push(push_a), .pop(pop_a),
    .value(value_a), .top(top_a), .data_out(data_out_a), .out_valid(out_valid_a),
    .count(count_a), .empty(empty_a), .full(full_a), .overflow(overflow_a),
    .underflow(underflow_a)
  );

  param_lifo_stack #(.DATA_WIDTH(16), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst_b), .clear(clear_b), .push(push_b), .pop(pop_b),
    .value(value_b), .top(top_b), .data_out(data_out_b), .out_valid(out_valid_b),
    .count(count_b), .empty(empty_b), .full(full_b), .overflow(overflow_b),
    .underflow(underflow_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on instance A, sample 1 ns after the edge, then go idle.
  task automatic applyStimulus(input logic r, input logic c, input logic pu,
                               input logic po, input logic [7:0] v);
    rst_a = r; clear_a = c; push_a = pu; pop_a = po; value_a = v;
    @(posedge clk);
    #1;
    rst_a = 1'b1; clear_a = 1'b0; push_a = 1'b0; pop_a = 1'b0; value_a = 8'h00;
  endtask

  task automatic applyStimulusWide(input logic r, input logic pu, input logic po,
                                   input logic [15:0] v);
    rst_b = r; clear_b = 1'b0; push_b = pu; pop_b = po; value_b = v;
    @(posedge clk);
    #1;
    rst_b = 1'b1; push_b = 1'b0; pop_b = 1'b0; value_b = 16'h0000;
  endtask

  initial begin
    logic [7:0] pat_a [3];
    pat_a[0] = 8'h33; pat_a[1] = 8'h22; pat_a[2] = 8'h11;

    rst_a = 1'b0; clear_a = 1'b0; push_a = 1'b0; pop_a = 1'b0; value_a = 8'h00;
    rst_b = 1'b0; clear_b = 1'b0; push_b = 1'b0; pop_b = 1'b0; value_b = 16'h0000;

    // Reset
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_count", 32'(count_a), 32'd0);
    checkOutput("rst_empty", 32'(empty_a), 32'd1);
    checkOutput("rst_full", 32'(full_a), 32'd0);
    checkOutput("rst_top", 32'(top_a), 32'h00);
    checkOutput("rst_valid", 32'(out_valid_a), 32'd0);
    checkOutput("rst_ovf", 32'(overflow_a), 32'd0);
    checkOutput("rst_udf", 32'(underflow_a), 32'd0);

    // LIFO order
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
    checkOutput("lifo_count", 32'(count_a), 32'd3);
    checkOutput("lifo_top", 32'(top_a), 32'h33);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("lifo_data", 32'(data_out_a), 32'(pat_a[i]));
      checkOutput("lifo_valid", 32'(out_valid_a), 32'd1);
    end
    checkOutput("lifo_empty", 32'(empty_a), 32'd1);
    checkOutput("lifo_top0", 32'(top_a), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("idle_valid", 32'(out_valid_a), 32'd0);

    // Full / overflow
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    checkOutput("full_flag", 32'(full_a), 32'd1);
    checkOutput("full_count", 32'(count_a), 32'd4);
    checkOutput("full_ovf", 32'(overflow_a), 32'd1);
    checkOutput("full_top", 32'(top_a), 32'hA3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("drain_data", 32'(data_out_a), 32'hA3 - 32'(i));
    end
    checkOutput("ovf_sticky", 32'(overflow_a), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("clr_ovf", 32'(overflow_a), 32'd0);

    // Underflow and simultaneous push+pop
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("udf_flag", 32'(underflow_a), 32'd1);
    checkOutput("udf_valid", 32'(out_valid_a), 32'd0);
    checkOutput("udf_count", 32'(count_a), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("pp_empty_count", 32'(count_a), 32'd1);
    checkOutput("pp_empty_top", 32'(top_a), 32'h5A);
    checkOutput("pp_empty_valid", 32'(out_valid_a), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h6B);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h7C);
    checkOutput("rep_data", 32'(data_out_a), 32'h6B);
    checkOutput("rep_valid", 32'(out_valid_a), 32'd1);
    checkOutput("rep_count", 32'(count_a), 32'd2);
    checkOutput("rep_top", 32'(top_a), 32'h7C);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("rep_pop", 32'(data_out_a), 32'h7C);
    checkOutput("rep_top2", 32'(top_a), 32'h5A);

    // Replace-top while full raises no error
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hC0 + 8'(i));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'hD9);
    checkOutput("repfull_data", 32'(data_out_a), 32'hC3);
    checkOutput("repfull_top", 32'(top_a), 32'hD9);
    checkOutput("repfull_ovf", 32'(overflow_a), 32'd0);

    // Clear mid-operation: count=3, overflow=1
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("pre_clr_count", 32'(count_a), 32'd3);
    checkOutput("pre_clr_ovf", 32'(overflow_a), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
    checkOutput("clr_count", 32'(count_a), 32'd0);
    checkOutput("clr_ovf2", 32'(overflow_a), 32'd0);
    checkOutput("clr_top", 32'(top_a), 32'h00);
    checkOutput("clr_hold", 32'(data_out_a), 32'hD9);

    // Reset alongside pop
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h44);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("rstpop_count", 32'(count_a), 32'd0);
    checkOutput("rstpop_valid", 32'(out_valid_a), 32'd0);
    checkOutput("rstpop_data", 32'(data_out_a), 32'h00);
    checkOutput("rstpop_empty", 32'(empty_a), 32'd1);

    // DEPTH=5, DATA_WIDTH=16
    applyStimulusWide(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulusWide(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) applyStimulusWide(1'b1, 1'b1, 1'b0, 16'h1000 + 16'(i));
    checkOutput("b_count", 32'(count_b), 32'd5);
    checkOutput("b_ovf", 32'(overflow_b), 32'd1);
    checkOutput("b_full", 32'(full_b), 32'd1);
    checkOutput("b_top", 32'(top_b), 32'h1004);
    for (int i = 0; i < 5; i++) begin
      applyStimulusWide(1'b1, 1'b0, 1'b1, 16'h0000);
      checkOutput("b_data", 32'(data_out_b), 32'h1004 - 32'(i));
      checkOutput("b_valid", 32'(out_valid_b), 32'd1);
    end
    applyStimulusWide(1'b1, 1'b0, 1'b1, 16'h0000);
    checkOutput("b_udf", 32'(underflow_b), 32'd1);
    checkOutput("b_udf_count", 32'(count_b), 32'd0);
    checkOutput("b_udf_valid", 32'(out_valid_b), 32'd0);
    checkOutput("b_udf_hold", 32'(data_out_b), 32'h1000);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
